// File: rtl/slave_port_arbiter_pkg.sv
// rtl/slave_port_arbiter_pkg.sv - shared types, width helpers and defaults for the slave port arbiter
package slave_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_MAX_XFERS   = 4;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width needed for a hold counter saturating at max_xfers
  function automatic int hold_w(input int max_xfers);
    return $clog2(max_xfers + 1);
  endfunction

  localparam int HOLD_W = $clog2(DEF_MAX_XFERS + 1);

endpackage

// File: rtl/slave_port_arbiter_if.sv
// rtl/slave_port_arbiter_if.sv - request/lock, muxed Avalon handshake and grant signals of the arbiter
interface slave_port_arbiter_if
  import slave_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_W       = clog2_min1(NUM_MASTERS)
);

  logic [NUM_MASTERS-1:0] i_Req;
  logic [NUM_MASTERS-1:0] i_Lock;
  logic                   i_AVOut_Read;
  logic                   i_AVOut_Write;
  logic                   i_AVOut_WaitRequest;
  logic [NUM_MASTERS-1:0] o_Gnt;
  logic [IDX_W-1:0]       o_GntIdx;
  logic                   o_GntValid;

  // Requester / interconnect side
  modport master (
    output i_Req, i_Lock, i_AVOut_Read, i_AVOut_Write, i_AVOut_WaitRequest,
    input  o_Gnt, o_GntIdx, o_GntValid
  );

  // Arbiter side
  modport slave (
    input  i_Req, i_Lock, i_AVOut_Read, i_AVOut_Write, i_AVOut_WaitRequest,
    output o_Gnt, o_GntIdx, o_GntValid
  );

endinterface

// File: rtl/slave_port_arbiter_rr_priority_select.sv
// rtl/slave_port_arbiter_rr_priority_select.sv - rotating-priority encoder: first request after the last winner
module rr_priority_select
  import slave_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_W       = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [IDX_W-1:0]       winner,
  output logic                   found
);

  logic [IDX_W-1:0] cand_idx;

  // Scan farthest-to-nearest from last+1 so the nearest set request is written last and wins
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(last) + k) % NUM_MASTERS);
      if (req[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// rtl/slave_port_arbiter.sv - round-robin grant owner for a shared Avalon slave port with lock and hold limit
module slave_port_arbiter
  import slave_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int MAX_XFERS   = DEF_MAX_XFERS,
  parameter int IDX_W       = clog2_min1(NUM_MASTERS)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  slave_port_arbiter_if.slave  bus
);

  localparam int                CNT_W    = hold_w(MAX_XFERS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_XFERS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_XFERS - 1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0]       winner;
  logic                   found;
  logic                   xfer_done, busy;
  logic                   own_req, own_lock, others_req, limit_hit, release_gnt;

  rr_priority_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_select (
    .req    (bus.i_Req),
    .last   (last_q),
    .winner (winner),
    .found  (found)
  );

  // Handshake decode and release decision for the current owner
  always_comb begin
    xfer_done   = (bus.i_AVOut_Read | bus.i_AVOut_Write) & ~bus.i_AVOut_WaitRequest;
    busy        = (bus.i_AVOut_Read | bus.i_AVOut_Write) &  bus.i_AVOut_WaitRequest;
    own_req     = bus.i_Req[idx_q];
    own_lock    = bus.i_Lock[idx_q];
    others_req  = |(bus.i_Req & ~gnt_q);
    limit_hit   = xfer_done && (cnt_q >= CNT_LAST);
    // A dropped request never leaves mid-transfer; the hold limit only bites unlocked owners with competition
    release_gnt = (!own_req && !busy) || (!own_lock && limit_hit && others_req);
  end

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: grant from IDLE when anyone asks, fall back to IDLE on release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)       state_d = OWNED;
      OWNED:   if (release_gnt) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Next values of the registered grant outputs, round-robin pointer and hold counter
  always_comb begin
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_MASTERS'(1) << winner;
          idx_d   = winner;
          valid_d = 1'b1;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      OWNED: begin
        if (release_gnt) begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (xfer_done && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Grant outputs and arbitration bookkeeping registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_Gnt      = gnt_q;
  assign bus.o_GntIdx   = idx_q;
  assign bus.o_GntValid = valid_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb/tb_slave_port_arbiter.sv - directed and randomized checks of slave_port_arbiter against a behavioural model
module tb_slave_port_arbiter;

  localparam int NM = 4;
  localparam int MX = 4;

  logic r_Clk = 1'b0;
  logic r_Rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: owner (-1 = none), round-robin pointer, completed transfers, held index
  int m_owner = -1;
  int m_last  = NM - 1;
  int m_cnt   = 0;
  int m_idx   = 0;

  slave_port_arbiter_if #(.NUM_MASTERS(NM), .IDX_W(2)) bif ();

  slave_port_arbiter #(
    .NUM_MASTERS (NM),
    .MAX_XFERS   (MX),
    .IDX_W       (2)
  ) dut (
    .i_Clk   (r_Clk),
    .i_Rst_n (r_Rst_n),
    .bus     (bif)
  );

  always #5 r_Clk = ~r_Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NM-1:0] r;
    logic [NM-1:0] l;
    bit xd, bz, others, rel;
    int c;
    r  = bif.i_Req;
    l  = bif.i_Lock;
    xd = (bif.i_AVOut_Read || bif.i_AVOut_Write) && !bif.i_AVOut_WaitRequest;
    bz = (bif.i_AVOut_Read || bif.i_AVOut_Write) &&  bif.i_AVOut_WaitRequest;
    if (m_owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        c = (m_last + k) % NM;
        if (r[c[1:0]]) begin
          m_owner = c;
          m_last  = c;
          m_idx   = c;
          m_cnt   = 0;
          break;
        end
      end
    end else begin
      c = m_owner;
      others = 1'b0;
      for (int i = 0; i < NM; i++)
        if (i != c && r[i[1:0]]) others = 1'b1;
      rel = (!r[c[1:0]] && !bz) || (!l[c[1:0]] && xd && (m_cnt + 1 >= MX) && others);
      if (rel) m_owner = -1;
      else if (xd && m_cnt < MX) m_cnt++;
    end
  endtask

  // Model advance on each clock edge, reset asynchronously like the design
  initial begin
    forever begin
      @(posedge r_Clk or negedge r_Rst_n);
      if (!r_Rst_n) begin
        m_owner = -1;
        m_last  = NM - 1;
        m_cnt   = 0;
        m_idx   = 0;
      end else begin
        model_step();
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge r_Clk);
      chk("model_gnt",   int'(bif.o_Gnt),      (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model_valid", int'(bif.o_GntValid), (m_owner < 0) ? 0 : 1);
      chk("model_idx",   int'(bif.o_GntIdx),   m_idx);
    end
  end

  task automatic tick();
    @(posedge r_Clk);
    #1;
  endtask

  task automatic bus_set(input logic wr, input logic wt);
    bif.i_AVOut_Write       = wr;
    bif.i_AVOut_WaitRequest = wt;
  endtask

  initial begin
    bif.i_Req = '0;
    bif.i_Lock = '0;
    bif.i_AVOut_Read = 1'b0;
    bif.i_AVOut_Write = 1'b0;
    bif.i_AVOut_WaitRequest = 1'b0;
    repeat (3) tick();
    chk("rst_gnt",   int'(bif.o_Gnt), 0);
    chk("rst_valid", int'(bif.o_GntValid), 0);
    chk("rst_idx",   int'(bif.o_GntIdx), 0);
    r_Rst_n = 1'b1;
    tick();
    chk("idle_gnt", int'(bif.o_Gnt), 0);

    // Two requesters, unlocked M0 yields after MAX_XFERS writes with one wait cycle each
    bif.i_Req = 4'b0011;
    tick();
    chk("first_gnt", int'(bif.o_Gnt), 1);
    chk("first_idx", int'(bif.o_GntIdx), 0);
    for (int k = 0; k < MX; k++) begin
      bus_set(1'b1, 1'b1); tick(); chk("limit_wait", int'(bif.o_Gnt), 1);
      bus_set(1'b1, 1'b0); tick(); chk("limit_done", int'(bif.o_Gnt), (k == MX - 1) ? 0 : 1);
    end
    bus_set(1'b0, 1'b0);
    tick();
    chk("limit_next", int'(bif.o_Gnt), 2);
    chk("limit_next_idx", int'(bif.o_GntIdx), 1);
    bif.i_Req = '0;
    tick();
    chk("drop_idle", int'(bif.o_Gnt), 0);
    chk("drop_idx_held", int'(bif.o_GntIdx), 1);

    // Locked M0 keeps the port for 8 writes despite M1 waiting
    bif.i_Req = 4'b0011;
    bif.i_Lock = 4'b0001;
    tick();
    chk("lock_gnt", int'(bif.o_Gnt), 1);
    for (int k = 0; k < 8; k++) begin
      bus_set(1'b1, 1'b1); tick(); chk("lock_wait", int'(bif.o_Gnt), 1);
      bus_set(1'b1, 1'b0); tick(); chk("lock_done", int'(bif.o_Gnt), 1);
    end
    bif.i_Req = 4'b0010;
    bif.i_Lock = '0;
    bus_set(1'b0, 1'b0);
    tick();
    chk("lock_dead", int'(bif.o_Gnt), 0);
    tick();
    chk("lock_next", int'(bif.o_Gnt), 2);
    bif.i_Req = '0;
    tick();

    // Request drops during a stalled write: grant held until the handshake completes
    bif.i_Req = 4'b0001;
    tick();
    chk("busy_gnt", int'(bif.o_Gnt), 1);
    bif.i_Req = '0;
    bus_set(1'b1, 1'b1);
    repeat (3) begin
      tick();
      chk("busy_hold", int'(bif.o_Gnt), 1);
    end
    bus_set(1'b1, 1'b0);
    tick();
    chk("busy_drop", int'(bif.o_Gnt), 0);
    bus_set(1'b0, 1'b0);
    tick();

    // Lone requester is never forced off by the hold limit
    bif.i_Req = 4'b0001;
    tick();
    chk("solo_gnt", int'(bif.o_Gnt), 1);
    bus_set(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("solo_hold", int'(bif.o_Gnt), 1);
    end
    bif.i_Req = '0;
    bus_set(1'b0, 1'b0);
    tick();
    chk("solo_drop", int'(bif.o_Gnt), 0);

    // All four requesting: rotation 1,2,3,0 with a dead cycle between owners
    bif.i_Req = 4'b1111;
    for (int j = 0; j < NM; j++) begin
      tick();
      chk("rr_gnt", int'(bif.o_Gnt), 1 << ((j + 1) % NM));
      bus_set(1'b1, 1'b0);
      repeat (MX - 1) begin
        tick();
        chk("rr_hold", int'(bif.o_Gnt), 1 << ((j + 1) % NM));
      end
      tick();
      chk("rr_dead", int'(bif.o_Gnt), 0);
      bus_set(1'b0, 1'b0);
    end
    bif.i_Req = 4'b0001;
    tick();
    chk("rr_self_regrant", int'(bif.o_Gnt), 1);
    bif.i_Req = '0;
    tick();

    // Asynchronous reset mid-write drops the grant without a clock edge
    bif.i_Req = 4'b0010;
    tick();
    chk("ar_gnt", int'(bif.o_Gnt), 2);
    bus_set(1'b1, 1'b1);
    tick();
    #2;
    r_Rst_n = 1'b0;
    #1;
    chk("ar_gnt_zero", int'(bif.o_Gnt), 0);
    chk("ar_valid_zero", int'(bif.o_GntValid), 0);
    bus_set(1'b0, 1'b0);
    bif.i_Req = 4'b0011;
    tick();
    tick();
    r_Rst_n = 1'b1;
    tick();
    chk("ar_first_m0", int'(bif.o_Gnt), 1);
    bif.i_Req = '0;
    tick();

    // Randomized traffic checked by the model, with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) bif.i_Req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) bif.i_Lock = 4'($urandom & $urandom);
      bif.i_AVOut_Read        = ($urandom_range(0, 3) == 0);
      bif.i_AVOut_Write       = ($urandom_range(0, 2) == 0);
      bif.i_AVOut_WaitRequest = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 r_Rst_n = 1'b0;
        #1 r_Rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
